// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and constants for the FIFO-fed UART transmitter.
package fifo_uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // Level the serial line rests at between frames (also the stop-bit level).
  localparam logic TX_IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts CLKS_PER_BIT clocks and pulses bit_end on the last
// clock of every serial bit. Cleared by rst and by load, which the transmitter
// drives on the cycle it leaves IDLE, so every frame starts on a clean bit
// boundary.
module fifo_uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cyc_cnt;

  // Free-running 0..CLKS_PER_BIT-1 counter; wraps at LAST so it never overflows.
  always_ff @(posedge clk) begin
    if (rst || load) begin
      cyc_cnt <= '0;
    end else if (cyc_cnt == LAST) begin
      cyc_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + CW'(1);
    end
  end

  assign bit_end = (cyc_cnt == LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO-fed UART transmitter: pops one M-bit word from the FIFO read channel
// whenever idle and sends it as start bit, M data bits LSB first, optional
// even parity bit, stop bit.
// Build option: define FIFO_UART_TX_PARITY_EN to insert the even-parity bit.
//
// Handshake: fifo_dout is valid whenever fifo_empty is low; a word is consumed
// in exactly the cycle fifo_read is high (only in IDLE, never in reset), and is
// captured into the shift register on that same clock edge.
module fifo_uart_tx
  import fifo_uart_tx_pkg::*;
#(
  parameter int M            = 16,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [M-1:0] fifo_dout,
  input  logic         fifo_empty,
  output logic         fifo_read,
  output logic         tx,
  output logic         busy
);

  localparam int IDX_W = $clog2(M + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(M - 1);

  tx_state_t        state_q, state_n;
  logic [M-1:0]     shift_q, shift_n;
  logic [IDX_W-1:0] bit_idx_q, bit_idx_n;
  logic             tx_q, tx_n;
  logic             bit_end;
`ifdef FIFO_UART_TX_PARITY_EN
  logic             parity_q, parity_n;
`endif

  fifo_uart_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (fifo_read),
    .bit_end(bit_end)
  );

  // State, datapath and line registers; tx is registered so fifo_dout never
  // reaches the pin combinationally.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= TX_IDLE_LEVEL;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      shift_q   <= shift_n;
      bit_idx_q <= bit_idx_n;
      tx_q      <= tx_n;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_q  <= parity_n;
`endif
    end
  end

  // Next-state logic, pop request and the line level for the next state.
  always_comb begin
    state_n   = state_q;
    shift_n   = shift_q;
    bit_idx_n = bit_idx_q;
    fifo_read = 1'b0;
`ifdef FIFO_UART_TX_PARITY_EN
    parity_n  = parity_q;
`endif

    case (state_q)
      IDLE: begin
        fifo_read = !rst && !fifo_empty;
        if (fifo_read) begin
          shift_n   = fifo_dout;
          bit_idx_n = '0;
          state_n   = START;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_n  = ^fifo_dout;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          bit_idx_n = '0;
          state_n   = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_n   = shift_q >> 1;
          bit_idx_n = bit_idx_q + IDX_W'(1);
          if (bit_idx_q == LAST_IDX) begin
`ifdef FIFO_UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end
        end
      end
      PARITY: begin
`ifdef FIFO_UART_TX_PARITY_EN
        if (bit_end) begin
          state_n = STOP;
        end
`else
        // Unreachable without the parity option; recover to IDLE.
        state_n = IDLE;
`endif
      end
      STOP: begin
        if (bit_end) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    case (state_n)
      START:   tx_n = ~TX_IDLE_LEVEL;
      DATA:    tx_n = shift_n[0];
`ifdef FIFO_UART_TX_PARITY_EN
      PARITY:  tx_n = parity_n;
`endif
      default: tx_n = TX_IDLE_LEVEL;
    endcase
  end

  assign tx   = tx_q;
  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed testbench for fifo_uart_tx: a queue-based FIFO model feeds words,
// expected per-cycle tx/busy/fifo_read values are built from each word's frame
// layout, and outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

  localparam int M   = 16;
  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME = (M + 2 + PBITS) * CPB;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [M-1:0] fifo_dout = '0;
  logic         fifo_empty = 1'b1;
  logic         fifo_read;
  logic         tx;
  logic         busy;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .M           (M),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_dout (fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_read (fifo_read),
    .tx        (tx),
    .busy      (busy)
  );

  // ---------------- FIFO model and expected queues ----------------
  logic [M-1:0] fq[$];
  logic         exp_tx_q[$];
  logic         exp_busy_q[$];
  logic         exp_rd_q[$];

  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   rd_cnt   = 0;
  int   busy_cnt = 0;
  logic s_tx, s_busy, s_rd;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_fifo();
    fifo_empty = (fq.size() == 0);
    fifo_dout  = (fq.size() == 0) ? '0 : fq[0];
  endtask

  // One clock: sample outputs mid-cycle, then apply the pop after the edge.
  task automatic tick();
    @(negedge clk);
    s_tx   = tx;
    s_busy = busy;
    s_rd   = fifo_read;
    if (s_rd) rd_cnt++;
    if (s_busy) busy_cnt++;
    @(posedge clk);
    #1;
    if (s_rd && fq.size() > 0) void'(fq.pop_front());
    drive_fifo();
  endtask

  // Line level at frame cycle f (0 = first start-bit cycle).
  function automatic logic frame_bit(input logic [M-1:0] w, input int f);
    int b;
    b = f / CPB;
    if (b == 0) return 1'b0;
    if (b <= M) return w[b-1];
    if (PBITS == 1 && b == M + 1) return ^w;
    return 1'b1;
  endfunction

  task automatic push_idle(input logic rd);
    exp_tx_q.push_back(1'b1);
    exp_busy_q.push_back(1'b0);
    exp_rd_q.push_back(rd);
  endtask

  task automatic push_frame(input logic [M-1:0] w, input int first, input int last);
    for (int f = first; f <= last; f++) begin
      exp_tx_q.push_back(frame_bit(w, f));
      exp_busy_q.push_back(1'b1);
      exp_rd_q.push_back(1'b0);
    end
  endtask

  task automatic run_expect(input string tag);
    logic e_tx, e_busy, e_rd;
    while (exp_tx_q.size() > 0) begin
      e_tx   = exp_tx_q.pop_front();
      e_busy = exp_busy_q.pop_front();
      e_rd   = exp_rd_q.pop_front();
      tick();
      check_eq({tag, "_tx"},   {31'd0, s_tx},   {31'd0, e_tx});
      check_eq({tag, "_busy"}, {31'd0, s_busy}, {31'd0, e_busy});
      check_eq({tag, "_read"}, {31'd0, s_rd},   {31'd0, e_rd});
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset held with a word waiting: no pop, line idle.
    fq.push_back(16'hA5C3);
    drive_fifo();
    @(posedge clk);
    #1;
    repeat (3) push_idle(1'b0);
    run_expect("reset");
    rst = 1'b0;

    // Single word: pop in the first cycle after reset, then a 72-cycle frame.
    rd_cnt   = 0;
    busy_cnt = 0;
    push_idle(1'b1);
    push_frame(16'hA5C3, 0, FRAME - 1);
    repeat (6) push_idle(1'b0);
    run_expect("single");
    check_eq("single_reads", rd_cnt, 1);
    check_eq("single_busy_len", busy_cnt, FRAME);

    // Back-to-back: three queued words, one IDLE cycle between frames.
    fq.push_back(16'h0001);
    fq.push_back(16'hFFFF);
    fq.push_back(16'h8000);
    drive_fifo();
    rd_cnt = 0;
    push_idle(1'b1); push_frame(16'h0001, 0, FRAME - 1);
    push_idle(1'b1); push_frame(16'hFFFF, 0, FRAME - 1);
    push_idle(1'b1); push_frame(16'h8000, 0, FRAME - 1);
    repeat (20) push_idle(1'b0);
    run_expect("b2b");
    check_eq("b2b_reads", rd_cnt, 3);
    check_eq("b2b_fifo_left", fq.size(), 0);

    // Empty FIFO: line stays idle, no pops.
    rd_cnt = 0;
    repeat (100) push_idle(1'b0);
    run_expect("empty");
    check_eq("empty_reads", rd_cnt, 0);

    // Reset during data bit 7 (frame cycles 32..35): word lost, next word sent.
    fq.push_back(16'h1234);
    fq.push_back(16'h00F0);
    drive_fifo();
    rd_cnt = 0;
    push_idle(1'b1);
    push_frame(16'h1234, 0, 32);
    run_expect("midrst_pre");
    rst = 1'b1;
    push_frame(16'h1234, 33, 33);
    run_expect("midrst_hit");
    rst = 1'b0;
    push_idle(1'b1);
    push_frame(16'h00F0, 0, FRAME - 1);
    repeat (6) push_idle(1'b0);
    run_expect("midrst_post");
    check_eq("midrst_reads", rd_cnt, 2);
    check_eq("midrst_fifo_left", fq.size(), 0);

`ifdef FIFO_UART_TX_PARITY_EN
    // Parity words: 0x0007 has odd weight (parity 1), 0x0003 even (parity 0).
    fq.push_back(16'h0007);
    fq.push_back(16'h0003);
    drive_fifo();
    busy_cnt = 0;
    push_idle(1'b1); push_frame(16'h0007, 0, FRAME - 1);
    push_idle(1'b1); push_frame(16'h0003, 0, FRAME - 1);
    repeat (6) push_idle(1'b0);
    run_expect("parity");
    check_eq("parity_busy_len", busy_cnt, 2 * 76);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
